// File: rtl/pkt_hdr_rd_sched.sv
// -----------------------------------------------------------------------------
// pkt_hdr_rd_sched
//
// Scheduler/reader for the double-buffered 64x128 packet header RAM.
// Picks one of 8 header slots in the active bank round-robin under an enable
// mask. It reads the slot's 4 RAM lines and emits them as a 4-beat, 134-bit
// packet (head / middle / middle / tail). A programmable idle gap follows
// each tail. The bank is taken from the writer's bank pointer only when a new
// packet is selected, so a bank switch never splits a packet.
//
// Optional feature (macro PKT_HDR_SEQ_STAMP_EN):
//   defined   - the tail beat's [31:0] carries the packet sequence number. This
//               is the pre-increment value of out_sched_pkt_cnt.
//   undefined - the RAM payload passes through unchanged.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_sched_addr_shift    writer bank pointer (read bank = this value)
//   in_sched_test_start    level, enables scheduling
//   in_sched_test_stop     level, stop after the current packet
//   in_sched_slot_mask     per-slot enable, bit i enables slot i
//   in_sched_gap           idle cycles inserted after each tail
//   out_sched_hdr_rd       RAM read enable
//   out_sched_hdr_addr     RAM address {bank, slot, line}
//   in_sched_hdr_rdata     RAM read data, valid 1 cycle after rd
//   out_sched_data         {flag[1:0], 4'b0, payload[127:0]}
//   out_sched_data_wr      beat valid
//   in_sched_data_alf      downstream almost-full, sampled only at SELECT
//   out_sched_slot_id      slot of the packet in flight or last sent
//   out_sched_pkt_cnt      packets emitted since reset
// -----------------------------------------------------------------------------
module pkt_hdr_rd_sched #(
    parameter int LINES_PER_SLOT = 4,
    parameter int GAP_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_sched_addr_shift,
    input  logic               in_sched_test_start,
    input  logic               in_sched_test_stop,
    input  logic [7:0]         in_sched_slot_mask,
    input  logic [GAP_W-1:0]   in_sched_gap,
    output logic               out_sched_hdr_rd,
    output logic [5:0]         out_sched_hdr_addr,
    input  logic [127:0]       in_sched_hdr_rdata,
    output logic [133:0]       out_sched_data,
    output logic               out_sched_data_wr,
    input  logic               in_sched_data_alf,
    output logic [2:0]         out_sched_slot_id,
    output logic [31:0]        out_sched_pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_READ,
        S_DRAIN,
        S_GAP
    } state_t;

    localparam logic [1:0] LAST_LINE = 2'(LINES_PER_SLOT - 1);
    localparam logic [1:0] FLAG_HEAD = 2'b01;
    localparam logic [1:0] FLAG_MID  = 2'b11;
    localparam logic [1:0] FLAG_TAIL = 2'b10;

    state_t             state_q,   state_d;
    logic               bank_q,    bank_d;
    logic [2:0]         slot_q,    slot_d;
    logic [1:0]         line_q,    line_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               rd_q,      rd_d;
    logic [5:0]         addr_q,    addr_d;
    logic               wr_q,      wr_d;
    logic [1:0]         flag_q,    flag_d;
    logic [31:0]        pkt_cnt_q, pkt_cnt_d;

    logic [2:0]         rr_slot;
    logic [127:0]       payload;

    // Round-robin pick: first enabled slot strictly after the last one,
    // searching upward modulo 8. Scanning k from far to near lets the nearest
    // hit win. The default covers the case where only the current slot is set.
    always_comb begin
        rr_slot = slot_q;
        for (int k = 7; k >= 1; k--) begin
            if (in_sched_slot_mask[slot_q + 3'(k)]) begin
                rr_slot = slot_q + 3'(k);
            end
        end
    end

    // NOTE: every signal gets a default before the case statement. Otherwise a
    // path that does not assign it would infer a latch.
    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        slot_d    = slot_q;
        line_d    = line_q;
        gap_cnt_d = gap_cnt_q;
        rd_d      = 1'b0;
        addr_d    = addr_q;
        pkt_cnt_d = pkt_cnt_q;

        // The RAM answers one cycle after rd, so the beat valid and its flag
        // trail the read by exactly one register stage.
        wr_d   = rd_q;
        flag_d = (line_q == 2'd0)      ? FLAG_HEAD :
                 (line_q == LAST_LINE) ? FLAG_TAIL : FLAG_MID;

        case (state_q)
            S_IDLE: begin
                if (in_sched_test_start && !in_sched_test_stop) begin
                    state_d = S_SELECT;
                end
            end

            S_SELECT: begin
                if (in_sched_test_stop || !in_sched_test_start) begin
                    state_d = S_IDLE;
                end else if ((in_sched_slot_mask != 8'd0) && !in_sched_data_alf) begin
                    // Bank and slot are latched here and frozen for the packet.
                    state_d = S_READ;
                    bank_d  = in_sched_addr_shift;
                    slot_d  = rr_slot;
                    line_d  = 2'd0;
                    rd_d    = 1'b1;
                    addr_d  = {in_sched_addr_shift, rr_slot, 2'd0};
                end
            end

            S_READ: begin
                // line_q is the line whose read is on the bus this cycle.
                if (line_q == LAST_LINE) begin
                    state_d = S_DRAIN;
                end else begin
                    line_d = line_q + 2'd1;
                    rd_d   = 1'b1;
                    addr_d = {bank_q, slot_q, line_q + 2'd1};
                end
            end

            S_DRAIN: begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
                if (in_sched_test_stop) begin
                    state_d = S_IDLE;
                end else if (in_sched_gap == '0) begin
                    state_d = S_SELECT;
                end else begin
                    gap_cnt_d = in_sched_gap - GAP_W'(1);
                    state_d   = S_GAP;
                end
            end

            S_GAP: begin
                if (in_sched_test_stop) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_SELECT;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bank_q    <= 1'b0;
            slot_q    <= 3'd7;
            line_q    <= 2'd0;
            gap_cnt_q <= '0;
            rd_q      <= 1'b0;
            addr_q    <= 6'd0;
            wr_q      <= 1'b0;
            flag_q    <= 2'b00;
            pkt_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            slot_q    <= slot_d;
            line_q    <= line_d;
            gap_cnt_q <= gap_cnt_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            flag_q    <= flag_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

`ifdef PKT_HDR_SEQ_STAMP_EN
    // The tail beat is emitted in DRAIN, before pkt_cnt_q increments, so the
    // stamp is the pre-increment sequence number.
    assign payload = (flag_q == FLAG_TAIL) ? {in_sched_hdr_rdata[127:32], pkt_cnt_q}
                                           : in_sched_hdr_rdata;
`else
    assign payload = in_sched_hdr_rdata;
`endif

    // RAM data arrives in the beat cycle itself. The beat is gated by the
    // registered valid so the bus reads 0 when idle and right after reset.
    assign out_sched_data    = wr_q ? {flag_q, 4'b0000, payload} : 134'd0;
    assign out_sched_data_wr = wr_q;
    assign out_sched_hdr_rd  = rd_q;
    assign out_sched_hdr_addr = addr_q;
    assign out_sched_slot_id = slot_q;
    assign out_sched_pkt_cnt = pkt_cnt_q;

endmodule
